muldiv_unit: RTL and testbench

Iterative multiply/divide coprocessor with architectural HI/LO registers, serving MULTU, DIVU, MFHI, MFLO, MTHI and MTLO in the single-cycle MIPS core.
- One operation at a time, one radix-2 step per cycle.
- Exports `busy` so the core's hazard logic stalls MFHI/MFLO and any new MULTU/DIVU until results are architecturally visible.
- Sits beside the ALU; operands come from the register-file read ports.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply/divide coprocessor that owns the architectural
// HI/LO registers. One radix-2 step is performed per clock, so a MULTU or DIVU
// keeps the unit busy for WIDTH+1 cycles: WIDTH RUN cycles and one DONE cycle.
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous active-high reset (highest priority)
//   start  : launch request, sampled only in IDLE
//   op     : 0 = MULTU, 1 = DIVU (sampled with start)
//   a      : multiplicand / dividend (sampled with start)
//   b      : multiplier / divisor (sampled with start)
//   hi_we  : MTHI write enable, honoured only in IDLE when start is low
//   lo_we  : MTLO write enable, honoured only in IDLE when start is low
//   wdata  : write data for MTHI/MTLO
//   busy   : high whenever the unit is not IDLE
//   done   : one-cycle pulse while in DONE
//   hi     : HI register (product upper half / remainder)
//   lo     : LO register (product lower half / quotient)
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Multiply: upper_q/lower_q form P. Divide: upper_q is R, lower_q is Q.
    logic [WIDTH-1:0]   upper_q, upper_d;
    logic [WIDTH-1:0]   lower_q, lower_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, done_q;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   step_upper_s;
    logic [WIDTH-1:0]   step_lower_s;

    // One radix-2 iteration of the selected algorithm on the working registers.
    always_comb begin
        mul_sum_s   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {upper_q, lower_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        // R < b holds before every step (or b = 0, where the top bit stays
        // clear), so the difference fits in WIDTH+1 signed bits and its sign
        // bit alone decides whether the trial subtraction succeeds.
        div_ge_s    = ~div_diff_s[WIDTH];
        if (op_q) begin
            step_upper_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            step_lower_s = {lower_q[WIDTH-2:0], div_ge_s};
        end else begin
            // Carry of the add drops into the top of P on the right shift.
            step_upper_s = mul_sum_s[WIDTH:1];
            step_lower_s = {mul_sum_s[0], lower_q[WIDTH-1:1]};
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and HI/LO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        upper_d = upper_q;
        lower_d = lower_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Both algorithms start from upper = 0, lower = a.
                    op_d    = op;
                    b_d     = b;
                    cnt_d   = {CNT_W{1'b0}};
                    upper_d = {WIDTH{1'b0}};
                    lower_d = a;
                    state_d = S_RUN;
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_RUN: begin
                upper_d = step_upper_s;
                lower_d = step_lower_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hi_d    = step_upper_s;
                    lo_d    = step_lower_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, working and architectural registers; flags registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 1'b0;
            b_q     <= {WIDTH{1'b0}};
            upper_q <= {WIDTH{1'b0}};
            lower_q <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared = 0;
    int failed   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        cyc();
        start = 1'b0;
    endtask

    // Count busy cycles and done pulses until the unit returns to IDLE (bounded).
    task automatic wait_idle(output int bc, output int dn);
        int n;
        bc = 0; dn = 0; n = 0;
        while (busy === 1'b1 && n < 200) begin
            bc++;
            if (done === 1'b1) dn++;
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", done); end
        compared++; if (hi !== 32'd0) begin failed++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        compared++; if (lo !== 32'd0) begin failed++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_multu_max();
        int bc, dn, n;
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bc = 0; dn = 0; n = 0;
        while (busy === 1'b1 && n < 200) begin
            bc++;
            if (done === 1'b1) begin
                dn++;
            end else begin
                compared++;
                if (hi !== 32'd0 || lo !== 32'd0) begin
                    failed++;
                    $display("FAIL multu_hold cycle %0d: got hi=%h lo=%h expected 00000000", bc, hi, lo);
                end
            end
            cyc();
            n++;
        end
        compared++; if (bc !== 33) begin failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        compared++; if (dn !== 1) begin failed++; $display("FAIL multu_done_count: got %0d expected 1", dn); end
        compared++; if (hi !== 32'hFFFF_FFFE) begin failed++; $display("FAIL multu_max_hi: got %h expected fffffffe", hi); end
        compared++; if (lo !== 32'h0000_0001) begin failed++; $display("FAIL multu_max_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_divu();
        int bc, dn;
        launch(1'b1, 32'd100, 32'd7);
        wait_idle(bc, dn);
        compared++; if (bc !== 33) begin failed++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
        compared++; if (lo !== 32'd14) begin failed++; $display("FAIL divu_100_7_lo: got %0d expected 14", lo); end
        compared++; if (hi !== 32'd2) begin failed++; $display("FAIL divu_100_7_hi: got %0d expected 2", hi); end
        launch(1'b1, 32'hFFFF_FFFF, 32'd16);
        wait_idle(bc, dn);
        compared++; if (lo !== 32'h0FFF_FFFF) begin failed++; $display("FAIL divu_max_16_lo: got %h expected 0fffffff", lo); end
        compared++; if (hi !== 32'h0000_000F) begin failed++; $display("FAIL divu_max_16_hi: got %h expected 0000000f", hi); end
        launch(1'b1, 32'h1234_5678, 32'd0);
        wait_idle(bc, dn);
        compared++; if (dn !== 1) begin failed++; $display("FAIL divu_zero_done: got %0d expected 1", dn); end
        compared++; if (lo !== 32'hFFFF_FFFF) begin failed++; $display("FAIL divu_by0_lo: got %h expected ffffffff", lo); end
        compared++; if (hi !== 32'h1234_5678) begin failed++; $display("FAIL divu_by0_hi: got %h expected 12345678", hi); end
    endtask

    task automatic test_zero_mult();
        int bc, dn;
        launch(1'b0, 32'd0, 32'h0000_1234);
        wait_idle(bc, dn);
        compared++; if (bc !== 33) begin failed++; $display("FAIL mult_zero_latency: got %0d expected 33", bc); end
        compared++; if (hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("FAIL mult_zero_result: got hi=%h lo=%h expected 0", hi, lo); end
    endtask

    task automatic test_ignored_start();
        int bc, dn;
        launch(1'b0, 32'd6, 32'd7);
        cyc(); cyc(); cyc(); cyc();
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
        cyc();
        start = 1'b0;
        wait_idle(bc, dn);
        compared++; if (bc !== 28) begin failed++; $display("FAIL ign_remaining_busy: got %0d expected 28", bc); end
        compared++; if (dn !== 1) begin failed++; $display("FAIL ign_done_count: got %0d expected 1", dn); end
        compared++; if (lo !== 32'd42) begin failed++; $display("FAIL ign_lo: got %0d expected 42", lo); end
        compared++; if (hi !== 32'd0) begin failed++; $display("FAIL ign_hi: got %0d expected 0", hi); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failed++;
                $display("FAIL ign_no_relaunch idle cycle %0d: got busy=%b done=%b expected 0 0", i, busy, done);
            end
            cyc();
        end
    endtask

    task automatic test_mt_writes();
        int bc, dn;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        cyc();
        hi_we = 1'b0; lo_we = 1'b0;
        compared++; if (hi !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mthi_idle: got %h expected deadbeef", hi); end
        compared++; if (lo !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mtlo_idle: got %h expected deadbeef", lo); end
        hi_we = 1'b1; wdata = 32'h0000_0055;
        cyc();
        hi_we = 1'b0;
        compared++; if (hi !== 32'h0000_0055 || lo !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mthi_only: got hi=%h lo=%h expected 00000055 deadbeef", hi, lo); end
        launch(1'b0, 32'd2, 32'd3);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
        cyc();
        hi_we = 1'b0; lo_we = 1'b0;
        compared++; if (hi !== 32'h0000_0055 || lo !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mt_during_run: got hi=%h lo=%h expected 00000055 deadbeef", hi, lo); end
        wait_idle(bc, dn);
        compared++; if (lo !== 32'd6 || hi !== 32'd0) begin failed++; $display("FAIL mult_2x3: got hi=%h lo=%h expected 0 6", hi, lo); end
        start = 1'b1; op = 1'b0; a = 32'd4; b = 32'd5; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        cyc();
        start = 1'b0; lo_we = 1'b0;
        compared++; if (busy !== 1'b1) begin failed++; $display("FAIL start_with_mtlo_busy: got %b expected 1", busy); end
        compared++; if (lo !== 32'd6) begin failed++; $display("FAIL start_drops_mtlo: got %h expected 00000006", lo); end
        wait_idle(bc, dn);
        compared++; if (lo !== 32'd20 || hi !== 32'd0) begin failed++; $display("FAIL mult_4x5: got hi=%h lo=%h expected 0 20", hi, lo); end
    endtask

    task automatic test_reset_mid();
        int bc, dn;
        launch(1'b0, 32'd3, 32'd5);
        for (int i = 0; i < 9; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        compared++; if (hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("FAIL midreset_hilo: got hi=%h lo=%h expected 0 0", hi, lo); end
        launch(1'b0, 32'd3, 32'd5);
        wait_idle(bc, dn);
        compared++; if (bc !== 33) begin failed++; $display("FAIL after_reset_latency: got %0d expected 33", bc); end
        compared++; if (lo !== 32'd15 || hi !== 32'd0) begin failed++; $display("FAIL after_reset_3x5: got hi=%h lo=%h expected 0 15", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int nd, t1, t2;
        logic started2;
        logic [31:0] hi1, lo1;
        nd = 0; t1 = 0; t2 = 0; started2 = 1'b0; hi1 = 32'd0; lo1 = 32'd0;
        launch(1'b0, 32'h0001_0000, 32'h0001_0000);
        for (int t = 0; t < 200; t++) begin
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) begin t1 = t; hi1 = hi; lo1 = lo; end
                else t2 = t;
            end
            if (nd == 1 && busy === 1'b0 && !started2) begin
                start = 1'b1; op = 1'b1; a = 32'hFFFF_FFFF; b = 32'd16;
                started2 = 1'b1;
            end
            if (nd >= 2 && busy === 1'b0) break;
            cyc();
            start = 1'b0;
        end
        compared++; if (nd !== 2) begin failed++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
        compared++; if (hi1 !== 32'd1 || lo1 !== 32'd0) begin failed++; $display("FAIL b2b_first: got hi=%h lo=%h expected 1 0", hi1, lo1); end
        compared++; if (t2 - t1 !== 34) begin failed++; $display("FAIL b2b_spacing: got %0d expected 34", t2 - t1); end
        compared++; if (lo !== 32'h0FFF_FFFF || hi !== 32'h0000_000F) begin failed++; $display("FAIL b2b_second: got hi=%h lo=%h expected f 0fffffff", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_divu();
        test_zero_mult();
        test_ignored_start();
        test_mt_writes();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
